// File: rtl/vram_pkg.sv
// Shared VRAM geometry and the CPU-side arbitration state encoding.
package vram_pkg;

    localparam int VRAM_AW = 19;
    localparam int VRAM_DW = 12;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_RESP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// VGA, CPU and VRAM-core signals of the arbiter; master = surrounding system, slave = arbiter.
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) ();

    logic          vga_rdn;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          vga_miss;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ready;

    logic          vram_write;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_data_in;
    logic [DW-1:0] vram_out;

    modport master (
        output vga_rdn, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_out,
        input  vga_data, vga_miss, cpu_rdata, cpu_ready, vram_write, vram_addr, vram_data_in
    );

    modport slave (
        input  vga_rdn, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_out,
        output vga_data, vga_miss, cpu_rdata, cpu_ready, vram_write, vram_addr, vram_data_in
    );

endinterface

// File: rtl/vram_arbiter_wait_counter.sv
// Saturating starvation counter: clear, increment, and a flag at MAX_WAIT-1.
module arb_wait_counter #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_term
);

    localparam int CW = $clog2(MAX_WAIT) + 1;

    logic [CW-1:0] r_cnt;

    assign o_term = (r_cnt == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_term) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA owns every slot except the one-cycle CPU ISSUE slot,
// which the CPU gets when VGA is idle or forcibly after MAX_WAIT waiting cycles.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW       = VRAM_AW,
    parameter int DW       = VRAM_DW,
    parameter int MAX_WAIT = 16
) (
    input  logic           clk_100MHz,
    input  logic           rst,
    vram_arbiter_if.slave  bus
);

    state_t        r_state;
    state_t        w_next;

    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_vga_slot_d;
    logic [DW-1:0] r_vga_data;
    logic [DW-1:0] r_cpu_rdata;
    logic          r_vga_miss;

    logic          w_cpu_slot;
    logic          w_latch;
    logic          w_cnt_inc;
    logic          w_override;
    logic          w_wait_term;

    assign w_cpu_slot = (r_state == S_ISSUE);

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk    (clk_100MHz),
        .rst    (rst),
        .i_clr  (w_cpu_slot),
        .i_inc  (w_cnt_inc),
        .o_term (w_wait_term)
    );

    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_cnt_inc  = 1'b0;
        w_override = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    w_latch = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.vga_rdn) begin
                    w_next = S_ISSUE;
                end else if (w_wait_term) begin
                    w_next     = S_ISSUE;
                    w_override = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_ISSUE: w_next = S_RESP;
            S_RESP:  w_next = S_DONE;
            S_DONE: begin
                if (!bus.cpu_req) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_latch) begin
            r_we    <= bus.cpu_we;
            r_addr  <= bus.cpu_addr;
            r_wdata <= bus.cpu_wdata;
        end
    end

    // A VGA slot lost to the CPU leaves r_vga_slot_d low, so the previous pixel repeats.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_vga_slot_d <= 1'b0;
            r_vga_data   <= '0;
            r_cpu_rdata  <= '0;
            r_vga_miss   <= 1'b0;
        end else begin
            r_vga_slot_d <= !w_cpu_slot && !bus.vga_rdn;
            r_vga_miss   <= w_override;
            if (r_vga_slot_d) begin
                r_vga_data <= bus.vram_out;
            end
            if ((r_state == S_RESP) && !r_we) begin
                r_cpu_rdata <= bus.vram_out;
            end
        end
    end

    assign bus.vram_addr    = w_cpu_slot ? r_addr : bus.vga_addr;
    assign bus.vram_write   = w_cpu_slot && r_we;
    assign bus.vram_data_in = r_wdata;
    assign bus.vga_data     = r_vga_data;
    assign bus.vga_miss     = r_vga_miss;
    assign bus.cpu_rdata    = r_cpu_rdata;
    assign bus.cpu_ready    = (r_state == S_DONE);

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural 1-cycle-latency VRAM model.
module tb_vram_arbiter;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] mem [0:(1<<19)-1];

    logic [18:0] wq_addr [$];
    logic [11:0] wq_data [$];
    logic [11:0] rq [$];
    logic [11:0] vq [$];

    vram_arbiter_if bus ();

    vram_arbiter #(
        .AW       (19),
        .DW       (12),
        .MAX_WAIT (16)
    ) dut (
        .clk_100MHz (clk),
        .rst        (rst),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] pix(input logic [18:0] a);
        return a[11:0] ^ 12'h5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // VRAM model plus write monitor: every write must match the next expected one
    always @(posedge clk) begin
        bus.vram_out <= mem[bus.vram_addr];
        if (bus.vram_write) begin
            mem[bus.vram_addr] <= bus.vram_data_in;
            if (wq_addr.size() > 0) begin
                chk("wr_addr", 32'(bus.vram_addr), 32'(wq_addr.pop_front()));
                chk("wr_data", 32'(bus.vram_data_in), 32'(wq_data.pop_front()));
            end else begin
                chk("wr_unexpected", 32'(bus.vram_write), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_txn(input logic we, input logic [18:0] a, input logic [11:0] d,
                           input logic [11:0] exp_rd, input int exp_lat, input int hold);
        int  edges;
        bit  got;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        if (we) begin
            wq_addr.push_back(a);
            wq_data.push_back(d);
        end else begin
            rq.push_back(exp_rd);
        end
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 100) begin
            tick();
            edges++;
            if (edges == 1) begin
                bus.cpu_we    = ~we;
                bus.cpu_addr  = ~a;
                bus.cpu_wdata = ~d;
            end
            if (bus.cpu_ready) got = 1'b1;
        end
        chk("ready_lat", 32'(edges), 32'(exp_lat));
        if (!we && got) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(rq.pop_front()));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("ready_hold", 32'(bus.cpu_ready), 32'd1);
        end
        bus.cpu_req = 1'b0;
        tick();
        chk("ready_drop", 32'(bus.cpu_ready), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] last;
        bit          got;
        int          misses;

        for (int i = 0; i < (1 << 19); i++) mem[i] = pix(19'(i));
        mem[19'h12345] = 12'h5A5;

        rst           = 1'b1;
        bus.vga_rdn   = 1'b1;
        bus.vga_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;

        repeat (3) tick();
        chk("rst_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_write", 32'(bus.vram_write), 32'd0);
        chk("rst_miss", 32'(bus.vga_miss), 32'd0);
        chk("rst_vga_data", 32'(bus.vga_data), 32'd0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        rst = 1'b0;
        tick();

        // write, held 3 cycles after ready, then a 1-cycle gap into a readback
        cpu_txn(1'b1, 19'h00100, 12'hABC, 12'h000, 4, 3);
        cpu_txn(1'b0, 19'h00100, 12'h000, 12'hABC, 4, 0);

        cpu_txn(1'b0, 19'h12345, 12'h000, 12'h5A5, 4, 0);

        // VGA streams 8 pixels while a CPU read waits for the first free slot
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 19'h00200;
        rq.push_back(12'h7A5);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c < 8) begin
                bus.vga_rdn  = 1'b0;
                bus.vga_addr = 19'(c);
                vq.push_back(pix(19'(c)));
            end else begin
                bus.vga_rdn = 1'b1;
            end
            tick();
            chk("vga_nomiss", 32'(bus.vga_miss), 32'd0);
            if (c >= 1 && vq.size() > 0) chk("vga_data", 32'(bus.vga_data), 32'(vq.pop_front()));
            if (bus.cpu_ready && !got) begin
                got = 1'b1;
                chk("lat_vga_busy", 32'(c + 1), 32'd11);
                chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(rq.pop_front()));
            end
        end
        if (!got) chk("ready_timeout", 32'(bus.cpu_ready), 32'd1);
        bus.cpu_req = 1'b0;
        tick();
        chk("ready_drop", 32'(bus.cpu_ready), 32'd0);

        // VGA never idle: CPU write forced in after 16 WAIT cycles
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 19'h00300;
        bus.cpu_wdata = 12'h123;
        wq_addr.push_back(19'h00300);
        wq_data.push_back(12'h123);
        got    = 1'b0;
        misses = 0;
        last   = '0;
        for (int c = 0; c < 22; c++) begin
            bus.vga_rdn  = 1'b0;
            bus.vga_addr = 19'(19'h40 + c);
            last = (c == 17) ? last : pix(19'(19'h40 + c));
            vq.push_back(last);
            tick();
            if (bus.vga_miss) misses++;
            chk("vga_miss", 32'(bus.vga_miss), 32'(c == 16));
            if (c >= 1) chk("vga_data_ovr", 32'(bus.vga_data), 32'(vq.pop_front()));
            if (bus.cpu_ready && !got) begin
                got = 1'b1;
                chk("lat_override", 32'(c + 1), 32'd19);
            end
        end
        if (!got) chk("ready_timeout", 32'(bus.cpu_ready), 32'd1);
        chk("miss_count", 32'(misses), 32'd1);
        vq.delete();
        bus.cpu_req = 1'b0;
        bus.vga_rdn = 1'b1;
        tick();
        chk("ready_drop", 32'(bus.cpu_ready), 32'd0);
        cpu_txn(1'b0, 19'h00300, 12'h000, 12'h123, 4, 0);

        // asynchronous reset while the write is still waiting
        bus.vga_rdn   = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 19'h00400;
        bus.cpu_wdata = 12'hFFF;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", 32'(bus.cpu_ready), 32'd0);
        chk("arst_write", 32'(bus.vram_write), 32'd0);
        chk("arst_miss", 32'(bus.vga_miss), 32'd0);
        chk("arst_vga_data", 32'(bus.vga_data), 32'd0);
        chk("arst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        tick();
        tick();
        bus.cpu_req = 1'b0;
        bus.vga_rdn = 1'b1;
        rst = 1'b0;
        repeat (25) tick();
        cpu_txn(1'b0, 19'h00400, 12'h000, 12'h1A5, 4, 0);

        chk("wr_pending", 32'(wq_addr.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
